frame_map_req_ctrl: RTL and testbench
=====================================

Name: frame_map_req_ctrl

Overview:
Parametrised successor to the sender-side map data-request logic. Owns the frame row/column counters instead of taking them as inputs. Classifies every column slot as overhead, payload, pad or fill, and issues registered pop requests to the payload FIFO. Supports retransmission hold, frame start/stop gating, a stall-vs-fill underrun mode, and an underrun statistic. Sits between the payload FIFO and the frame mapper/line FIFO.

Parameters:
ROWS, 4, rows per frame
COLS, 1041, columns per row (index 0..COLS-1)
OH_COLS, 16, leading overhead columns per row (cols 0..OH_COLS-1)
PAD_COLS, 1, trailing pad columns per row (cols COLS-PAD_COLS..COLS-1)
ROW_W, 2, row counter width, >= clog2(ROWS)
COL_W, 11, column counter width, >= clog2(COLS)
STALL_W, 16, underrun counter width

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_enable  in  1  start/continue framing; sampled at frame boundaries only
i_fill_mode  in  1  0 = stall on payload underrun, 1 = emit fill slot
i_pyld_data_valid  in  1  payload FIFO has data
i_line_fifo_ready  in  1  line FIFO can accept a slot
i_tran_rec_fifo_ready  in  1  transmit-record FIFO can accept a slot
i_line_retrans_req  in  1  retransmission in progress; freeze mapping
o_data_req  out  1  registered pop strobe to payload FIFO
o_slot_valid  out  1  registered; a slot is emitted this cycle
o_slot_type  out  2  0 OH, 1 PYLD, 2 PAD, 3 FILL; qualified by o_slot_valid
o_row_cnt  out  ROW_W  row of emitted slot
o_col_cnt  out  COL_W  column of emitted slot
o_sof  out  1  registered; emitted slot is row 0 col 0
o_busy  out  1  FSM not in IDLE
o_stall_cnt  out  STALL_W  saturating count of underrun events

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; internal row/col=0; all outputs 0.
- adv = i_line_fifo_ready & i_tran_rec_fifo_ready & !i_line_retrans_req.
- Current column class: col<OH_COLS -> OH; col>=COLS-PAD_COLS -> PAD; else PYLD.
- FSM states: IDLE, RUN, HOLD.
- IDLE: outputs valid/req 0. i_enable=1 -> RUN at row 0 col 0.
- RUN, per cycle:
  - i_line_retrans_req=1 -> HOLD; no slot; counters hold.
  - else if !adv: no slot, counters hold.
  - else OH/PAD column: emit slot (type OH/PAD, o_data_req=0), advance.
  - else PYLD with i_pyld_data_valid=1: emit PYLD, o_data_req=1, advance.
  - else PYLD without data and i_fill_mode=0: no slot, hold, o_stall_cnt+1.
  - else PYLD without data and i_fill_mode=1: emit FILL, o_data_req=0, advance, o_stall_cnt+1.
- Advance: col+1. At col=COLS-1, col wraps to 0 and row+1. At row=ROWS-1 and col=COLS-1 (frame end): row wraps to 0; i_enable=0 -> IDLE, else stay in RUN.
- HOLD: no slots, counters frozen. i_line_retrans_req deassert -> RUN, resuming at the frozen position on the next cycle. Retrans has priority over all other conditions.
- Output registration:
  - All slot outputs are registered; one-cycle latency from the decision cycle.
  - o_row_cnt/o_col_cnt/o_sof carry the pre-advance position.
  - o_data_req and o_slot_valid are 0 on any cycle with no slot.
- o_data_req is never 1 unless i_pyld_data_valid was 1 in the decision cycle (no FIFO over-read).
- o_stall_cnt saturates at all-ones; cleared only by reset.
- i_enable deassert mid-frame is ignored until frame end.
- Async reset mid-frame: immediate return to IDLE/row 0/col 0, outputs 0.
- o_busy = (FSM != IDLE), registered.

Test Plan:
- Reset then i_enable=1, all ready, valid=1 constant, defaults: per row, 16 OH slots, 1024 PYLD with o_data_req=1, then 1 PAD at col 1040. o_sof on first slot only. 4164 slots per frame. o_stall_cnt=0.
- i_fill_mode=0, valid dropped for 5 cycles at col 100: no slots for 5 cycles, position held at col 100, o_stall_cnt=5. Resume at col 100, no slot lost.
- i_fill_mode=1, same gap: 5 FILL slots at cols 100..104, o_data_req=0 on them, o_stall_cnt=5.
- i_line_retrans_req high for 10 cycles at row 2 col 500: zero slots and o_data_req=0 throughout. Next slot after release is row 2 col 500.
- i_enable dropped at row 1: framing continues to row 3 col 1040, then IDLE. o_busy falls one cycle after the last slot.
- Async i_rst pulsed mid-payload (not clock-aligned): all outputs 0 immediately. After release and i_enable, the next slot is row 0 col 0 with o_sof=1.

Source files
------------

// File: rtl/frame_map_req_ctrl.sv
// Sender-side frame map request controller.
// Owns the frame row/column position, classifies each column slot as overhead,
// payload, pad or fill, and issues registered pop requests to the payload FIFO.
// Mapping freezes during retransmission; framing starts/stops only at frame
// boundaries; payload underrun either stalls or emits a fill slot.
module frame_map_req_ctrl #(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 1041,
  parameter int unsigned OH_COLS  = 16,
  parameter int unsigned PAD_COLS = 1,
  parameter int unsigned ROW_W    = 2,
  parameter int unsigned COL_W    = 11,
  parameter int unsigned STALL_W  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_fill_mode,
  input  logic               i_pyld_data_valid,
  input  logic               i_line_fifo_ready,
  input  logic               i_tran_rec_fifo_ready,
  input  logic               i_line_retrans_req,
  output logic               o_data_req,
  output logic               o_slot_valid,
  output logic [1:0]         o_slot_type,
  output logic [ROW_W-1:0]   o_row_cnt,
  output logic [COL_W-1:0]   o_col_cnt,
  output logic               o_sof,
  output logic               o_busy,
  output logic [STALL_W-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } state_e;

  localparam logic [1:0] SlotOh   = 2'd0;
  localparam logic [1:0] SlotPyld = 2'd1;
  localparam logic [1:0] SlotPad  = 2'd2;
  localparam logic [1:0] SlotFill = 2'd3;

  localparam logic [COL_W-1:0] ColLast  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] RowLast  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] OhEnd    = COL_W'(OH_COLS);
  localparam logic [COL_W-1:0] PadStart = COL_W'(COLS - PAD_COLS);

  state_e state_q, state_d;

  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;

  logic               data_req_q, data_req_d;
  logic               slot_valid_q, slot_valid_d;
  logic [1:0]         slot_type_q, slot_type_d;
  logic [ROW_W-1:0]   row_out_q, row_out_d;
  logic [COL_W-1:0]   col_out_q, col_out_d;
  logic               sof_q, sof_d;
  logic               busy_q, busy_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       adv;
  logic [1:0] col_class;
  logic       emit;
  logic       underrun;

  // Downstream can take a slot and no retransmission is freezing the map.
  assign adv = i_line_fifo_ready & i_tran_rec_fifo_ready & ~i_line_retrans_req;

  // Column classification of the current (pre-advance) position.
  always_comb begin
    col_class = SlotPyld;
    if (col_q < OhEnd) begin
      col_class = SlotOh;
    end else if (col_q >= PadStart) begin
      col_class = SlotPad;
    end
  end

  // FSM next state, slot decision, position advance and stall accounting.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    emit         = 1'b0;
    underrun     = 1'b0;
    data_req_d   = 1'b0;
    slot_valid_d = 1'b0;
    slot_type_d  = SlotOh;
    row_out_d    = '0;
    col_out_d    = '0;
    sof_d        = 1'b0;
    stall_cnt_d  = stall_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (i_enable) begin
          state_d = StRun;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StRun: begin
        if (i_line_retrans_req) begin
          state_d = StHold;
        end else if (adv) begin
          if (col_class != SlotPyld) begin
            emit        = 1'b1;
            slot_type_d = col_class;
          end else if (i_pyld_data_valid) begin
            emit        = 1'b1;
            slot_type_d = SlotPyld;
            data_req_d  = 1'b1;
          end else if (!i_fill_mode) begin
            // Stall: hold position and wait for payload.
            underrun = 1'b1;
          end else begin
            emit        = 1'b1;
            slot_type_d = SlotFill;
            underrun    = 1'b1;
          end
        end
      end
      StHold: begin
        // Release only re-arms RUN; the frozen slot is decided next cycle.
        if (!i_line_retrans_req) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (emit) begin
      slot_valid_d = 1'b1;
      row_out_d    = row_q;
      col_out_d    = col_q;
      sof_d        = (row_q == '0) && (col_q == '0);
      if (col_q == ColLast) begin
        col_d = '0;
        if (row_q == RowLast) begin
          row_d = '0;
          // Frame boundary is the only point where i_enable is honoured.
          if (!i_enable) begin
            state_d = StIdle;
          end
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (underrun && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // Registered from the current state so it lines up with the slot outputs.
    busy_d = (state_q != StIdle);
  end

  // State, position and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= StIdle;
      row_q        <= '0;
      col_q        <= '0;
      data_req_q   <= 1'b0;
      slot_valid_q <= 1'b0;
      slot_type_q  <= SlotOh;
      row_out_q    <= '0;
      col_out_q    <= '0;
      sof_q        <= 1'b0;
      busy_q       <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      data_req_q   <= data_req_d;
      slot_valid_q <= slot_valid_d;
      slot_type_q  <= slot_type_d;
      row_out_q    <= row_out_d;
      col_out_q    <= col_out_d;
      sof_q        <= sof_d;
      busy_q       <= busy_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign o_data_req   = data_req_q;
  assign o_slot_valid = slot_valid_q;
  assign o_slot_type  = slot_type_q;
  assign o_row_cnt    = row_out_q;
  assign o_col_cnt    = col_out_q;
  assign o_sof        = sof_q;
  assign o_busy       = busy_q;
  assign o_stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_frame_map_req_ctrl.sv
// Directed self-checking bench for frame_map_req_ctrl with default geometry.
module tb_frame_map_req_ctrl;

  localparam int ROWS    = 4;
  localparam int COLS    = 1041;
  localparam int OH_COLS = 16;
  localparam int ROW_W   = 2;
  localparam int COL_W   = 11;
  localparam int STALL_W = 16;
  localparam int BUDGET  = 10000;

  logic               i_clk;
  logic               i_rst;
  logic               i_enable;
  logic               i_fill_mode;
  logic               i_pyld_data_valid;
  logic               i_line_fifo_ready;
  logic               i_tran_rec_fifo_ready;
  logic               i_line_retrans_req;
  logic               o_data_req;
  logic               o_slot_valid;
  logic [1:0]         o_slot_type;
  logic [ROW_W-1:0]   o_row_cnt;
  logic [COL_W-1:0]   o_col_cnt;
  logic               o_sof;
  logic               o_busy;
  logic [STALL_W-1:0] o_stall_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  frame_map_req_ctrl dut (
    .i_clk                 (i_clk),
    .i_rst                 (i_rst),
    .i_enable              (i_enable),
    .i_fill_mode           (i_fill_mode),
    .i_pyld_data_valid     (i_pyld_data_valid),
    .i_line_fifo_ready     (i_line_fifo_ready),
    .i_tran_rec_fifo_ready (i_tran_rec_fifo_ready),
    .i_line_retrans_req    (i_line_retrans_req),
    .o_data_req            (o_data_req),
    .o_slot_valid          (o_slot_valid),
    .o_slot_type           (o_slot_type),
    .o_row_cnt             (o_row_cnt),
    .o_col_cnt             (o_col_cnt),
    .o_sof                 (o_sof),
    .o_busy                (o_busy),
    .o_stall_cnt           (o_stall_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Tick until a slot at (r, c) is seen, or the budget expires.
  task automatic wait_slot(input int r, input int c, output bit hit);
    hit = 1'b0;
    for (int n = 0; n < BUDGET && !hit; n++) begin
      tick();
      hit = o_slot_valid && (int'(o_row_cnt) == r) && (int'(o_col_cnt) == c);
    end
  endtask

  function automatic int exp_type(input int c);
    if (c < OH_COLS) return 0;
    if (c == COLS - 1) return 2;
    return 1;
  endfunction

  task automatic test_reset();
    i_rst                 = 1'b1;
    i_enable              = 1'b0;
    i_fill_mode           = 1'b0;
    i_pyld_data_valid     = 1'b0;
    i_line_fifo_ready     = 1'b0;
    i_tran_rec_fifo_ready = 1'b0;
    i_line_retrans_req    = 1'b0;
    repeat (3) tick();
    vec_cnt++;
    if ({o_data_req, o_slot_valid, o_slot_type, o_row_cnt, o_col_cnt, o_sof, o_busy,
         o_stall_cnt} !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got valid=%b req=%b busy=%b stall=%0d, want all 0",
               o_slot_valid, o_data_req, o_busy, o_stall_cnt);
    end
    i_rst = 1'b0;
    repeat (3) tick();
    vec_cnt++;
    if (o_slot_valid !== 1'b0 || o_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL idle_no_enable: got valid=%b busy=%b, want 0 0", o_slot_valid, o_busy);
    end
  endtask

  task automatic test_full_frame();
    int got = 0;
    int er = 0;
    int ec = 0;
    int n = 0;
    i_line_fifo_ready     = 1'b1;
    i_tran_rec_fifo_ready = 1'b1;
    i_pyld_data_valid     = 1'b1;
    i_enable              = 1'b1;
    while (got < ROWS * COLS && n < BUDGET) begin
      tick();
      n++;
      if (o_slot_valid) begin
        int et;
        bit es;
        et = exp_type(ec);
        es = (er == 0) && (ec == 0);
        vec_cnt++;
        if (int'(o_row_cnt) != er || int'(o_col_cnt) != ec || int'(o_slot_type) != et ||
            o_data_req !== (et == 1) || o_sof !== es) begin
          err_cnt++;
          $display("FAIL frame_slot %0d: got r%0d c%0d t%0d req%b sof%b, want r%0d c%0d t%0d req%b sof%b",
                   got, o_row_cnt, o_col_cnt, o_slot_type, o_data_req, o_sof,
                   er, ec, et, (et == 1), es);
        end
        got++;
        ec++;
        if (ec == COLS) begin
          ec = 0;
          er = (er + 1) % ROWS;
        end
      end
    end
    vec_cnt++;
    if (got != ROWS * COLS) begin
      err_cnt++;
      $display("FAIL frame_count: got %0d slots, want %0d", got, ROWS * COLS);
    end
    vec_cnt++;
    if (o_stall_cnt !== 16'd0 || o_busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL frame_status: got stall=%0d busy=%b, want 0 1", o_stall_cnt, o_busy);
    end
  endtask

  task automatic test_stall_gap();
    bit hit;
    i_fill_mode = 1'b0;
    wait_slot(0, 99, hit);
    vec_cnt++;
    if (!hit) begin
      err_cnt++;
      $display("FAIL stall_sync: slot r0 c99 not seen, want seen");
    end
    i_pyld_data_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vec_cnt++;
      if (o_slot_valid !== 1'b0 || o_data_req !== 1'b0 || int'(o_stall_cnt) != i + 1) begin
        err_cnt++;
        $display("FAIL stall_gap %0d: got valid=%b req=%b stall=%0d, want 0 0 %0d",
                 i, o_slot_valid, o_data_req, o_stall_cnt, i + 1);
      end
    end
    i_pyld_data_valid = 1'b1;
    tick();
    vec_cnt++;
    if (o_slot_valid !== 1'b1 || o_row_cnt !== 2'd0 || o_col_cnt !== 11'd100 ||
        o_slot_type !== 2'd1 || o_data_req !== 1'b1 || o_stall_cnt !== 16'd5) begin
      err_cnt++;
      $display("FAIL stall_resume: got v%b r%0d c%0d t%0d req%b stall=%0d, want v1 r0 c100 t1 req1 stall=5",
               o_slot_valid, o_row_cnt, o_col_cnt, o_slot_type, o_data_req, o_stall_cnt);
    end
  endtask

  task automatic test_fill_gap();
    bit hit;
    i_fill_mode = 1'b1;
    wait_slot(1, 99, hit);
    vec_cnt++;
    if (!hit) begin
      err_cnt++;
      $display("FAIL fill_sync: slot r1 c99 not seen, want seen");
    end
    i_pyld_data_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vec_cnt++;
      if (o_slot_valid !== 1'b1 || o_slot_type !== 2'd3 || o_row_cnt !== 2'd1 ||
          int'(o_col_cnt) != 100 + i || o_data_req !== 1'b0 || int'(o_stall_cnt) != 6 + i) begin
        err_cnt++;
        $display("FAIL fill_slot %0d: got v%b t%0d r%0d c%0d req%b stall=%0d, want v1 t3 r1 c%0d req0 stall=%0d",
                 i, o_slot_valid, o_slot_type, o_row_cnt, o_col_cnt, o_data_req, o_stall_cnt,
                 100 + i, 6 + i);
      end
    end
    i_pyld_data_valid = 1'b1;
    i_fill_mode       = 1'b0;
    tick();
    vec_cnt++;
    if (o_slot_valid !== 1'b1 || o_col_cnt !== 11'd105 || o_slot_type !== 2'd1 ||
        o_data_req !== 1'b1 || o_stall_cnt !== 16'd10) begin
      err_cnt++;
      $display("FAIL fill_resume: got v%b c%0d t%0d req%b stall=%0d, want v1 c105 t1 req1 stall=10",
               o_slot_valid, o_col_cnt, o_slot_type, o_data_req, o_stall_cnt);
    end
  endtask

  task automatic test_retrans();
    bit hit;
    bit seen;
    wait_slot(2, 499, hit);
    vec_cnt++;
    if (!hit) begin
      err_cnt++;
      $display("FAIL retrans_sync: slot r2 c499 not seen, want seen");
    end
    i_line_retrans_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      vec_cnt++;
      if (o_slot_valid !== 1'b0 || o_data_req !== 1'b0 || o_busy !== 1'b1) begin
        err_cnt++;
        $display("FAIL retrans_hold %0d: got valid=%b req=%b busy=%b, want 0 0 1",
                 i, o_slot_valid, o_data_req, o_busy);
      end
    end
    i_line_retrans_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = o_slot_valid;
    end
    vec_cnt++;
    if (!seen || o_row_cnt !== 2'd2 || o_col_cnt !== 11'd500 || o_slot_type !== 2'd1 ||
        o_data_req !== 1'b1) begin
      err_cnt++;
      $display("FAIL retrans_resume: got seen=%b r%0d c%0d t%0d req%b, want 1 r2 c500 t1 req1",
               seen, o_row_cnt, o_col_cnt, o_slot_type, o_data_req);
    end
  endtask

  task automatic test_enable_drop();
    bit hit;
    wait_slot(1, 10, hit);
    vec_cnt++;
    if (!hit) begin
      err_cnt++;
      $display("FAIL en_sync: slot r1 c10 not seen, want seen");
    end
    i_enable = 1'b0;
    wait_slot(3, 1040, hit);
    vec_cnt++;
    if (!hit || o_slot_type !== 2'd2 || o_busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL en_last_slot: got hit=%b t%0d busy=%b, want 1 t2 busy1",
               hit, o_slot_type, o_busy);
    end
    tick();
    vec_cnt++;
    if (o_slot_valid !== 1'b0 || o_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL en_idle: got valid=%b busy=%b, want 0 0", o_slot_valid, o_busy);
    end
    repeat (5) tick();
    vec_cnt++;
    if (o_slot_valid !== 1'b0 || o_busy !== 1'b0 || o_data_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL en_stays_idle: got valid=%b busy=%b req=%b, want 0 0 0",
               o_slot_valid, o_busy, o_data_req);
    end
  endtask

  task automatic test_async_reset();
    bit hit;
    bit seen;
    i_enable = 1'b1;
    wait_slot(0, 300, hit);
    vec_cnt++;
    if (!hit) begin
      err_cnt++;
      $display("FAIL arst_sync: slot r0 c300 not seen, want seen");
    end
    #3;
    i_rst    = 1'b1;
    i_enable = 1'b0;
    #1;
    vec_cnt++;
    if ({o_data_req, o_slot_valid, o_slot_type, o_row_cnt, o_col_cnt, o_sof, o_busy,
         o_stall_cnt} !== '0) begin
      err_cnt++;
      $display("FAIL arst_outputs: got valid=%b req=%b c%0d busy=%b stall=%0d, want all 0",
               o_slot_valid, o_data_req, o_col_cnt, o_busy, o_stall_cnt);
    end
    #2;
    i_rst = 1'b0;
    repeat (2) tick();
    vec_cnt++;
    if (o_slot_valid !== 1'b0 || o_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL arst_idle: got valid=%b busy=%b, want 0 0", o_slot_valid, o_busy);
    end
    i_enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = o_slot_valid;
    end
    vec_cnt++;
    if (!seen || o_row_cnt !== 2'd0 || o_col_cnt !== 11'd0 || o_sof !== 1'b1 ||
        o_slot_type !== 2'd0 || o_stall_cnt !== 16'd0) begin
      err_cnt++;
      $display("FAIL arst_restart: got seen=%b r%0d c%0d sof%b t%0d stall=%0d, want 1 r0 c0 sof1 t0 stall=0",
               seen, o_row_cnt, o_col_cnt, o_sof, o_slot_type, o_stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stall_gap();
    test_fill_gap();
    test_retrans();
    test_enable_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
